// File: rtl/io881_pkg.sv
// Shared types and widths for the writeback queue slice.
// Holds the register index / data widths, the default register-file size
// and the {dest, data} entry record carried through the writeback FIFO.
package io881_pkg;

  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 8;
  localparam int NREGS     = 8;

  // One pending register-file write: destination register and its value.
  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_fifo.sv
// wb_fifo: circular FIFO of writeback entries with head/tail pointers and
// an occupancy count one bit wider than the pointers. The whole storage
// array and the head pointer are exported so the parent can scan the
// queued entries (pending mask, forwarding) in age order.
// Push is ignored when full; pop is ignored when empty.
module wb_fifo
  import io881_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  wb_entry_t                    i_entry,
  input  logic                         i_pop,
  output wb_entry_t [DEPTH-1:0]        o_mem,
  output logic [$clog2(DEPTH)-1:0]     o_head_ptr,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  // Entry storage: write the incoming entry at the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (w_push) begin
      r_mem[r_tail] <= i_entry;
    end
  end

  // Head/tail pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_mem      = r_mem;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_full     = w_full;

endmodule

// File: rtl/wb_queue.sv
// wb_queue: writeback queue merging load and ALU results into one
// register-file write port. Loads have fixed priority; at most one entry
// is accepted per cycle. The head entry is written (wea) in every cycle
// the queue is non-empty, and popped in that same cycle.
// Handshake: a result is transferred at a posedge where valid && ready;
// ready never depends on the DUT's own valid, only on fullness (and, for
// the ALU port, on a competing load being offered).
// Optional feature: define WB_QUEUE_FWD_EN to enable forwarding of the
// youngest queued value for fwd_sel; otherwise fwd_hit/fwd_data are 0.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int NREGS = io881_pkg::NREGS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [io881_pkg::REG_IDX_W-1:0] ld_dest,
  input  logic [io881_pkg::DATA_W-1:0]    ld_data,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [io881_pkg::REG_IDX_W-1:0] alu_dest,
  input  logic [io881_pkg::DATA_W-1:0]    alu_data,
  output logic                           wea,
  output logic [io881_pkg::REG_IDX_W-1:0] wa,
  output logic [io881_pkg::DATA_W-1:0]    d8,
  output logic [NREGS-1:0]               pending,
  input  logic [io881_pkg::REG_IDX_W-1:0] fwd_sel,
  output logic                           fwd_hit,
  output logic [io881_pkg::DATA_W-1:0]    fwd_data
);

  import io881_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] w_mem;
  logic [PTR_W-1:0]      w_head_ptr;
  logic [CNT_W-1:0]      w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  wb_entry_t             w_entry;
  logic [NREGS-1:0]      w_pending;
  logic [PTR_W-1:0]      w_pend_slot;

  // Arbitration: load wins; ALU is held off whenever a load is offered.
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;
  assign w_push    = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign w_entry   = ld_valid ? '{dest: ld_dest, data: ld_data}
                              : '{dest: alu_dest, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_entry    (w_entry),
    .i_pop      (!w_empty),
    .o_mem      (w_mem),
    .o_head_ptr (w_head_ptr),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // Register-file port driven straight from the head; zeroed when idle.
  assign wea = !w_empty;
  assign wa  = w_empty ? '0 : w_mem[w_head_ptr].dest;
  assign d8  = w_empty ? '0 : w_mem[w_head_ptr].data;

  // Pending mask: OR of the destinations of every occupied slot.
  always_comb begin
    w_pending   = '0;
    w_pend_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend_slot = w_head_ptr + PTR_W'(i);
      if (CNT_W'(i) < w_count) w_pending[w_mem[w_pend_slot].dest] = 1'b1;
    end
  end

  assign pending = w_pending;

`ifdef WB_QUEUE_FWD_EN
  logic             w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PTR_W-1:0] w_fwd_slot;

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_slot = w_head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < w_count) && (w_mem[w_fwd_slot].dest == fwd_sel)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_mem[w_fwd_slot].data;
      end
    end
  end

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;
`else
  logic w_unused_fwd_sel;
  assign w_unused_fwd_sel = ^fwd_sel;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int NREGS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ld_valid, alu_valid;
  logic       ld_ready, alu_ready;
  logic [2:0] ld_dest, alu_dest, wa, fwd_sel;
  logic [7:0] ld_data, alu_data, d8, fwd_data;
  logic       wea, fwd_hit;
  logic [NREGS-1:0] pending;

  wb_queue #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .wea(wea), .wa(wa), .d8(d8), .pending(pending),
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

`ifdef WB_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];   // {dest, data}, oldest first

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: apply inputs and let combinational outputs settle.
  task automatic drive(input logic lv, input logic [2:0] ldst, input logic [7:0] ldat,
                       input logic av, input logic [2:0] adst, input logic [7:0] adat,
                       input logic [2:0] fs);
    ld_valid = lv; ld_dest = ldst; ld_data = ldat;
    alu_valid = av; alu_dest = adst; alu_data = adat;
    fwd_sel = fs;
    #1;
  endtask

  task automatic idle(input logic [2:0] fs);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, fs);
  endtask

  // Advance one clock; the model pops the oldest write and appends the
  // accepted result (load first, ALU only with no load and room).
  task automatic tick;
    bit full, acc_ld, acc_alu;
    full    = (exp_q.size() >= DEPTH);
    acc_ld  = ld_valid && !full;
    acc_alu = alu_valid && !full && !ld_valid;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc_ld) exp_q.push_back({ld_dest, ld_data});
    else if (acc_alu) exp_q.push_back({alu_dest, alu_data});
    @(negedge clk);
  endtask

  // Compare every output with what the model queue implies.
  task automatic check_model;
    logic [7:0] e_pend;
    logic       e_hit;
    logic [7:0] e_fd;
    logic [10:0] e;
    e_pend = '0; e_hit = 1'b0; e_fd = '0;
    foreach (exp_q[k]) begin
      e = exp_q[k];
      e_pend[e[10:8]] = 1'b1;
      if (FWD && e[10:8] == fwd_sel) begin e_hit = 1'b1; e_fd = e[7:0]; end
    end
    e = (exp_q.size() > 0) ? exp_q[0] : 11'd0;
    chk("m_wea", wea, exp_q.size() > 0);
    chk("m_wa", wa, e[10:8]);
    chk("m_d8", d8, e[7:0]);
    chk("m_pending", pending, e_pend);
    chk("m_ld_ready", ld_ready, exp_q.size() < DEPTH);
    chk("m_alu_ready", alu_ready, (exp_q.size() < DEPTH) && !ld_valid);
    chk("m_fwd_hit", fwd_hit, e_hit);
    chk("m_fwd_data", fwd_data, e_fd);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic lv; logic [2:0] ldst; logic [7:0] ldat;
    logic av; logic [2:0] adst; logic [7:0] adat;
    logic e_wea; logic [2:0] e_wa; logic [7:0] e_d8; logic [7:0] e_pend;
    logic e_ldr; logic e_alur;
  } vec_t;

  vec_t vecs[8];
  logic [10:0] sent[$];
  logic [10:0] got[$];

  initial begin
    // single ALU result, then load/ALU collision with ALU retried
    vecs[0] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hAA, 8'h08, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 3'd1, 8'h55, 1'b1, 3'd2, 8'hAA, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hAA, 1'b1, 3'd1, 8'h55, 8'h02, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hAA, 8'h04, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1};

    // reset state
    idle(3'd0);
    repeat (2) @(negedge clk);
    chk("rst_wea", wea, 1'b0);
    chk("rst_wa", wa, 3'd0);
    chk("rst_d8", d8, 8'h00);
    chk("rst_pending", pending, 8'h00);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_fwd_data", fwd_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].lv, vecs[i].ldst, vecs[i].ldat, vecs[i].av, vecs[i].adst, vecs[i].adat, 3'd0);
      chk($sformatf("v%0d_wea", i), wea, vecs[i].e_wea);
      chk($sformatf("v%0d_wa", i), wa, vecs[i].e_wa);
      chk($sformatf("v%0d_d8", i), d8, vecs[i].e_d8);
      chk($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
      chk($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_ldr);
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_alur);
      tick();
    end

    // DEPTH+1 back-to-back loads from empty
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i < DEPTH + 1) drive(1'b1, 3'(i), 8'(8'h30 + i), 1'b0, 3'd0, 8'h00, 3'd0);
      else idle(3'd0);
      check_model();
      tick();
    end

    // two results to the same register; forwarding sees the younger one
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h11, 3'd4);
    check_model();
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h22, 3'd4);
    chk("fwd_first_wa", wa, 3'd4);
    chk("fwd_first_d8", d8, 8'h11);
    check_model();
    tick();
    idle(3'd4);
    chk("fwd_hit_r4", fwd_hit, FWD);
    chk("fwd_data_r4", fwd_data, FWD ? 8'h22 : 8'h00);
    chk("fwd_second_d8", d8, 8'h22);
    check_model();
    tick();
    idle(3'd4);
    check_model();

    // asynchronous reset while an entry is queued
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h33, 3'd5);
    tick();
    idle(3'd5);
    chk("mid_wea_before", wea, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_wea", wea, 1'b0);
    chk("async_pending", pending, 8'h00);
    chk("async_fwd_hit", fwd_hit, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(3'd5);
      chk("post_rst_wea", wea, 1'b0);
      chk("post_rst_pending", pending, 8'h00);
      tick();
    end

    // 12 results across pointer wraps: write stream must equal input stream
    sent.delete(); got.delete();
    for (int i = 0; i < 15; i++) begin
      if (i < 12) begin
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 8'(8'h11 * i + 1), 3'd0);
        sent.push_back({3'(i), 8'(8'h11 * i + 1)});
      end else begin
        idle(3'd0);
      end
      if (wea) got.push_back({wa, d8});
      tick();
    end
    chk("wrap_count", 16'(got.size()), 16'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      chk($sformatf("wrap_%0d", i), got[i], sent[i]);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            3'($urandom_range(0, 7)));
      check_model();
      tick();
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
